ssd_scan_capture: RTL and testbench
===================================

// Module: ssd_scan_capture
// PURPOSE
//   Receive-side monitor for the multiplexed seven-segment bus (active-low segments a..g in [7:1], dp in [0]; active-low one-hot digit enable).
//   Samples the bus, debounces scan transitions, maps each segment pattern back to a 4-bit code, and assembles a 4-digit frame.
//   Used in loopback benches and on-board self-check of the display path.
// PARAMETERS
//   STABLE_CYCLES  4   consecutive cycles the registered {ctrl,display} must hold before a digit is captured (range 1..255)
// PORTS
//   clk          in   1   system clock; all logic on rising edge
//   rst          in   1   synchronous reset, active-high
//   ssd_display  in   8   segment bus, [7:1]=a..g active-low, [0]=dp active-low
//   ssd_ctrl     in   4   digit enables, active-low one-hot; bit0 = rightmost digit
//   bcd_out      out  16  per-digit decoded codes, nibble i = digit i
//   digit_valid  out  4   bit i set once digit i has been captured since reset
//   frame_bcd    out  16  snapshot of bcd_out when a full frame completes
//   frame_valid  out  1   1-cycle pulse when all 4 digits have been captured since the last frame
//   code_error   out  1   1-cycle pulse: captured pattern not in decode table
//   ctrl_error   out  1   1-cycle pulse: stable ssd_ctrl has more than one bit low
//   dp_out       out  4   captured decimal points, active-high (see CONFIGURATION)
// BEHAVIOUR
// - Reset: bcd_out=16'h0000, frame_bcd=16'h0000, digit_valid=0, dp_out=0, all pulses 0, seen mask=0, state IDLE, stable count=0.
//   A reset in mid-scan discards the partial frame.
// - Input stage: {ssd_ctrl,ssd_display} is registered once into in_q.
//   The stable counter is set to 1 on any cycle where in_q changes and increments otherwise, saturating at STABLE_CYCLES.
// - FSM: IDLE, SETTLE, HELD.
//   IDLE: in_q ctrl = 4'b1111 (blank) or counter < STABLE_CYCLES. Go to SETTLE on change.
//   SETTLE: when counter reaches STABLE_CYCLES, evaluate in_q ctrl.
//     Exactly one bit low: capture, then go to HELD.
//     All ones: go to IDLE, no capture, no error.
//     More than one bit low: pulse ctrl_error, go to HELD, no capture.
//   HELD: exactly one capture or error per dwell. Any in_q change returns to SETTLE (counter=1).
// - Latency: inputs constant from edge k make the captured nibble, digit_valid bit, and pulses visible after edge k+STABLE_CYCLES+1.
// - Decode table (display[7:1] -> code):
//   0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4,
//   0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0111000->F.
//   Any other pattern stores 4'hE in the nibble and pulses code_error. The digit still counts as captured.
// - Frame: seen mask |= captured digit bit.
//   When the mask becomes 4'hF, frame_bcd <= the updated bcd_out (including this capture) and frame_valid pulses, both on the same edge as the capture.
//   The mask clears on that edge. Re-capturing an already-seen digit overwrites its nibble and does not advance the frame.
// - A change shorter than STABLE_CYCLES produces no capture and no error.
// CONFIGURATION
// - SSD_CAP_DP_EN defined: on capture, dp_out[i] <= ~in_q display[0]. The dp bit is ignored for decode.
// - SSD_CAP_DP_EN undefined: dp_out tied to 4'b0000, no dp register. The dp bit is still ignored for decode.
// TESTING (STABLE_CYCLES=4)
// - Reset, ctrl=4'b1110, display=8'b0000110_1 held from edge k:
//   bcd_out[3:0]=3 and digit_valid=4'b0001 after edge k+5, not before; no pulses.
// - Scan digits 3..0 showing 1,2,3,4, 8 cycles each:
//   exactly one frame_valid pulse, on the edge digit 0 is captured; frame_bcd=16'h1234.
// - ctrl=4'b1101 for 2 cycles inside a 4'b1110 dwell: no capture of digit 1.
//   The digit 0 value is recaptured once after return.
// - Digit 2 with pattern 1111111_1: nibble 2 = E, one code_error pulse.
//   Pattern 0111000_1: nibble = F, no code_error.
// - ctrl=4'b1100 held 8 cycles: one ctrl_error pulse, bcd_out unchanged.
//   ctrl=4'b1111 held: no capture, no pulse.
// - Reset asserted after 3 of 4 digits: no frame_valid; a full scan is needed afterwards.
//   With SSD_CAP_DP_EN and display[0]=0 on digit 1: dp_out=4'b0010.

Source files
------------

// File: rtl/ssd_scan_capture.sv
// ssd_scan_capture: receive-side monitor for a multiplexed seven-segment bus.
// The bus is registered once, and the monitor waits until it has been stable for
// STABLE_CYCLES cycles. It then decodes the segment pattern of the enabled digit
// back to a 4-bit code and assembles 4-digit frames.
// Optional feature: define SSD_CAP_DP_EN to capture decimal points on dp_out;
// when it is undefined, dp_out is tied low.
module ssd_scan_capture #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  ssd_display,
   input  logic [3:0]  ssd_ctrl,
   output logic [15:0] bcd_out,
   output logic [3:0]  digit_valid,
   output logic [15:0] frame_bcd,
   output logic        frame_valid,
   output logic        code_error,
   output logic        ctrl_error,
   output logic [3:0]  dp_out
);

   localparam logic [7:0]  STABLE_C = 8'(STABLE_CYCLES);
   localparam logic [11:0] BLANK    = 12'hFFF;

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

   logic [11:0] in_q;
   logic        chg_q;
   logic [7:0]  cnt_q;
   state_t      state_q;
   logic [15:0] bcd_q;
   logic [3:0]  valid_q;
   logic [15:0] frame_q;
   logic        frame_valid_q;
   logic        code_error_q;
   logic        ctrl_error_q;
   logic [3:0]  seen_q;

   logic [3:0]  ctrl_low;
   logic        one_low;
   logic [1:0]  dig_idx;
   logic [4:0]  dec;
   logic [15:0] bcd_d;
   logic [3:0]  seen_d;
   logic        settle_done;

   // Map a[6]..g[0] (active low) to {error, code}; unknown patterns give E
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'b0000001: r = {1'b0, 4'h0};
         7'b1001111: r = {1'b0, 4'h1};
         7'b0010010: r = {1'b0, 4'h2};
         7'b0000110: r = {1'b0, 4'h3};
         7'b1001100: r = {1'b0, 4'h4};
         7'b0100100: r = {1'b0, 4'h5};
         7'b0100000: r = {1'b0, 4'h6};
         7'b0001111: r = {1'b0, 4'h7};
         7'b0000000: r = {1'b0, 4'h8};
         7'b0000100: r = {1'b0, 4'h9};
         7'b0111000: r = {1'b0, 4'hF};
         default:    r = {1'b1, 4'hE};
      endcase
      return r;
   endfunction

   // Work out what a capture of the held bus value would store
   always_comb begin
      // NOTE: every combinational output gets a default first, so no latch is inferred.
      ctrl_low = ~in_q[11:8];
      one_low  = (ctrl_low != 4'b0000) && ((ctrl_low & (ctrl_low - 4'd1)) == 4'b0000);
      dig_idx  = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (ctrl_low[i]) dig_idx = 2'(i);
      end
      dec   = decode_seg(in_q[7:1]);
      bcd_d = bcd_q;
      bcd_d[{dig_idx, 2'b00} +: 4] = dec[3:0];
      seen_d      = seen_q | ctrl_low;
      settle_done = (state_q == SETTLE) && !chg_q && (cnt_q == STABLE_C);
   end

   // Register the bus and count how long it has stayed unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         in_q  <= BLANK;
         chg_q <= 1'b0;
         cnt_q <= 8'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         in_q  <= {ssd_ctrl, ssd_display};
         chg_q <= ({ssd_ctrl, ssd_display} != in_q);
         if (chg_q) begin
            cnt_q <= 8'd1;
         end else if (cnt_q < STABLE_C) begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

   // Scan FSM: one capture or ctrl error per stable dwell; pulses are registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         bcd_q         <= 16'h0000;
         valid_q       <= 4'b0000;
         frame_q       <= 16'h0000;
         frame_valid_q <= 1'b0;
         code_error_q  <= 1'b0;
         ctrl_error_q  <= 1'b0;
         seen_q        <= 4'b0000;
      end else begin
         frame_valid_q <= 1'b0;
         code_error_q  <= 1'b0;
         ctrl_error_q  <= 1'b0;
         if (chg_q) begin
            state_q <= SETTLE;
         end else if (settle_done) begin
            if (one_low) begin
               state_q      <= HELD;
               bcd_q        <= bcd_d;
               valid_q      <= valid_q | ctrl_low;
               code_error_q <= dec[4];
               if (seen_d == 4'hF) begin
                  frame_q       <= bcd_d;
                  frame_valid_q <= 1'b1;
                  seen_q        <= 4'b0000;
               end else begin
                  seen_q <= seen_d;
               end
            end else if (ctrl_low == 4'b0000) begin
               state_q <= IDLE;
            end else begin
               ctrl_error_q <= 1'b1;
               state_q      <= HELD;
            end
         end
      end
   end

`ifdef SSD_CAP_DP_EN
   logic [3:0] dp_q;

   // Store the decimal point of each digit when that digit is captured
   always_ff @(posedge clk) begin
      if (rst) begin
         dp_q <= 4'b0000;
      end else if (settle_done && one_low) begin
         dp_q[dig_idx] <= ~in_q[0];
      end
   end

   assign dp_out = dp_q;
`else
   assign dp_out = 4'b0000;
`endif

   assign bcd_out     = bcd_q;
   assign digit_valid = valid_q;
   assign frame_bcd   = frame_q;
   assign frame_valid = frame_valid_q;
   assign code_error  = code_error_q;
   assign ctrl_error  = ctrl_error_q;

endmodule

// File: tb/tb_ssd_scan_capture.sv
// tb_ssd_scan_capture: table-driven decode vectors, hand-written scan sequences,
// and randomized dwells compared every cycle against a run-length reference model.
module tb_ssd_scan_capture;

   localparam int STABLE = 4;
   localparam int RUN_MAX = 1000;

   logic        clk;
   logic        rst;
   logic [7:0]  ssd_display;
   logic [3:0]  ssd_ctrl;
   logic [15:0] bcd_out;
   logic [3:0]  digit_valid;
   logic [15:0] frame_bcd;
   logic        frame_valid;
   logic        code_error;
   logic        ctrl_error;
   logic [3:0]  dp_out;

   ssd_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
      .clk         (clk),
      .rst         (rst),
      .ssd_display (ssd_display),
      .ssd_ctrl    (ssd_ctrl),
      .bcd_out     (bcd_out),
      .digit_valid (digit_valid),
      .frame_bcd   (frame_bcd),
      .frame_valid (frame_valid),
      .code_error  (code_error),
      .ctrl_error  (ctrl_error),
      .dp_out      (dp_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int fv_cnt  = 0;
   int ce_cnt  = 0;
   int cte_cnt = 0;

   // Reference model: a digit event fires one edge after the sampled bus has
   // been identical for STABLE+1 consecutive samples.
   logic [4:0]  dec_tab [128];
   logic [6:0]  seg_ok  [11];
   logic [11:0] m_prev;
   int          m_run;
   logic [15:0] m_bcd;
   logic [3:0]  m_valid;
   logic [15:0] m_frame;
   logic        m_fv;
   logic        m_ce;
   logic        m_cte;
   logic [3:0]  m_seen;
   logic [3:0]  m_dp;

   typedef struct {
      int         dig;
      logic [3:0] ctrl;
      logic [7:0] disp;
      logic [3:0] code;
      int         err;
   } vec_t;

   vec_t tv [13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_event(input logic [11:0] v);
      logic [3:0] low;
      logic [4:0] e;
      int         i;
      low = ~v[11:8];
      if ($countones(low) == 1) begin
         i = 0;
         for (int b = 0; b < 4; b++) if (low[b]) i = b;
         e = dec_tab[v[7:1]];
         m_bcd[i*4 +: 4] = e[3:0];
         m_ce       = e[4];
         m_valid[i] = 1'b1;
`ifdef SSD_CAP_DP_EN
         m_dp[i] = ~v[0];
`endif
         m_seen[i] = 1'b1;
         if (m_seen == 4'hF) begin
            m_frame = m_bcd;
            m_fv    = 1'b1;
            m_seen  = 4'h0;
         end
      end else if ($countones(low) > 1) begin
         m_cte = 1'b1;
      end
   endtask

   task automatic model_edge();
      logic [11:0] s;
      if (rst) begin
         m_prev = 12'hFFF; m_run = RUN_MAX;
         m_bcd = '0; m_valid = '0; m_frame = '0; m_seen = '0; m_dp = '0;
         m_fv = 1'b0; m_ce = 1'b0; m_cte = 1'b0;
      end else begin
         m_fv = 1'b0; m_ce = 1'b0; m_cte = 1'b0;
         if (m_run == STABLE + 1) model_event(m_prev);
         s = {ssd_ctrl, ssd_display};
         if (s == m_prev) begin
            if (m_run < RUN_MAX) m_run++;
         end else begin
            m_prev = s;
            m_run  = 1;
         end
      end
   endtask

   // One clock: advance the model on the edge, then compare the DUT 1 time unit later
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      fv_cnt  += int'(frame_valid);
      ce_cnt  += int'(code_error);
      cte_cnt += int'(ctrl_error);
      check("model_cycle",
            {21'd0, bcd_out, digit_valid, frame_bcd, frame_valid, code_error, ctrl_error, dp_out},
            {21'd0, m_bcd, m_valid, m_frame, m_fv, m_ce, m_cte, m_dp});
   endtask

   task automatic hold(input logic [3:0] c, input logic [7:0] d, input int n);
      ssd_ctrl    = c;
      ssd_display = d;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      ssd_ctrl    = 4'hF;
      ssd_display = 8'hFF;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic clr_counts();
      fv_cnt = 0; ce_cnt = 0; cte_cnt = 0;
   endtask

   logic [15:0] saved_bcd;
   logic [3:0]  rc;
   logic [7:0]  rd;
   int          sel;

   initial begin
      for (int i = 0; i < 128; i++) dec_tab[i] = {1'b1, 4'hE};
      seg_ok[0] = 7'b0000001; seg_ok[1] = 7'b1001111; seg_ok[2]  = 7'b0010010;
      seg_ok[3] = 7'b0000110; seg_ok[4] = 7'b1001100; seg_ok[5]  = 7'b0100100;
      seg_ok[6] = 7'b0100000; seg_ok[7] = 7'b0001111; seg_ok[8]  = 7'b0000000;
      seg_ok[9] = 7'b0000100; seg_ok[10] = 7'b0111000;
      for (int i = 0; i < 10; i++) dec_tab[seg_ok[i]] = {1'b0, 4'(i)};
      dec_tab[seg_ok[10]] = {1'b0, 4'hF};

      tv[0]  = '{0, 4'b1110, 8'b0000001_1, 4'h0, 0};
      tv[1]  = '{1, 4'b1101, 8'b1001111_1, 4'h1, 0};
      tv[2]  = '{2, 4'b1011, 8'b0010010_0, 4'h2, 0};
      tv[3]  = '{3, 4'b0111, 8'b0000110_1, 4'h3, 0};
      tv[4]  = '{0, 4'b1110, 8'b1001100_1, 4'h4, 0};
      tv[5]  = '{1, 4'b1101, 8'b0100100_0, 4'h5, 0};
      tv[6]  = '{2, 4'b1011, 8'b0100000_1, 4'h6, 0};
      tv[7]  = '{3, 4'b0111, 8'b0001111_1, 4'h7, 0};
      tv[8]  = '{0, 4'b1110, 8'b0000000_1, 4'h8, 0};
      tv[9]  = '{1, 4'b1101, 8'b0000100_1, 4'h9, 0};
      tv[10] = '{2, 4'b1011, 8'b0111000_1, 4'hF, 0};
      tv[11] = '{3, 4'b0111, 8'b1111111_1, 4'hE, 1};
      tv[12] = '{0, 4'b1110, 8'b0101010_0, 4'hE, 1};

      rst = 1'b1; ssd_ctrl = 4'hF; ssd_display = 8'hFF;

      // Reset state
      do_reset();
      check("reset_state",
            {21'd0, bcd_out, digit_valid, frame_bcd, frame_valid, code_error, ctrl_error, dp_out},
            64'd0);

      // Latency: capture visible after edge k+5, not after k+4
      clr_counts();
      hold(4'b1110, 8'b0000110_1, 5);
      check("latency_early_valid", 64'(digit_valid), 64'h0);
      tick();
      check("latency_nibble", 64'(bcd_out[3:0]), 64'h3);
      check("latency_valid", 64'(digit_valid), 64'h1);
      check("latency_pulses", 64'(fv_cnt + ce_cnt + cte_cnt), 64'd0);

      // Decode table vectors
      do_reset();
      for (int i = 0; i < 13; i++) begin
         clr_counts();
         hold(tv[i].ctrl, tv[i].disp, 8);
         check($sformatf("decode_vec%0d_code", i), 64'(bcd_out[tv[i].dig*4 +: 4]), 64'(tv[i].code));
         check($sformatf("decode_vec%0d_err", i), 64'(ce_cnt), 64'(tv[i].err));
      end

      // Full scan 1,2,3,4
      do_reset();
      clr_counts();
      hold(4'b0111, 8'b1001111_1, 8);
      hold(4'b1011, 8'b0010010_1, 8);
      hold(4'b1101, 8'b0000110_1, 8);
      check("scan_no_early_frame", 64'(fv_cnt), 64'd0);
      hold(4'b1110, 8'b1001100_1, 8);
      check("scan_frame_count", 64'(fv_cnt), 64'd1);
      check("scan_frame_bcd", 64'(frame_bcd), 64'h1234);

      // Short glitch to digit 1 inside a digit 0 dwell
      do_reset();
      clr_counts();
      hold(4'b1110, 8'b1001100_1, 8);
      hold(4'b1101, 8'b1001100_1, 2);
      hold(4'b1110, 8'b1001100_1, 10);
      check("glitch_valid", 64'(digit_valid), 64'h1);
      check("glitch_bcd", 64'(bcd_out), 64'h0004);
      check("glitch_pulses", 64'(fv_cnt + ce_cnt + cte_cnt), 64'd0);

      // Bad pattern then F pattern on digit 2
      clr_counts();
      hold(4'b1011, 8'b1111111_1, 8);
      check("bad_nibble", 64'(bcd_out[11:8]), 64'hE);
      check("bad_code_err", 64'(ce_cnt), 64'd1);
      clr_counts();
      hold(4'b1011, 8'b0111000_1, 8);
      check("f_nibble", 64'(bcd_out[11:8]), 64'hF);
      check("f_code_err", 64'(ce_cnt), 64'd0);

      // Multiple enables low, then blank
      saved_bcd = bcd_out;
      clr_counts();
      hold(4'b1100, 8'b0000110_1, 8);
      check("multi_ctrl_err", 64'(cte_cnt), 64'd1);
      check("multi_bcd", 64'(bcd_out), 64'(saved_bcd));
      clr_counts();
      hold(4'b1111, 8'b0000110_1, 8);
      check("blank_pulses", 64'(fv_cnt + ce_cnt + cte_cnt), 64'd0);
      check("blank_bcd", 64'(bcd_out), 64'(saved_bcd));

      // Reset after 3 of 4 digits discards the partial frame
      do_reset();
      clr_counts();
      hold(4'b0111, 8'b1001111_1, 8);
      hold(4'b1011, 8'b0010010_1, 8);
      hold(4'b1101, 8'b0000110_0, 8);
      do_reset();
      check("midreset_valid", 64'(digit_valid), 64'h0);
      hold(4'b1110, 8'b1001100_1, 8);
      check("midreset_no_frame", 64'(fv_cnt), 64'd0);
      hold(4'b0111, 8'b1001111_1, 8);
      hold(4'b1011, 8'b0010010_1, 8);
      hold(4'b1101, 8'b0000110_0, 8);
      check("midreset_frame", 64'(fv_cnt), 64'd1);
      check("midreset_frame_bcd", 64'(frame_bcd), 64'h1234);
`ifdef SSD_CAP_DP_EN
      check("dp_out", 64'(dp_out), 64'h2);
`else
      check("dp_out", 64'(dp_out), 64'h0);
`endif

      // Randomized dwells against the model
      do_reset();
      for (int n = 0; n < 300; n++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0, 1:    rc = 4'b1110;
            2, 3:    rc = 4'b1101;
            4:       rc = 4'b1011;
            5:       rc = 4'b0111;
            6:       rc = 4'b1111;
            default: rc = 4'($urandom);
         endcase
         if ($urandom_range(0, 1) == 0) rd = {seg_ok[$urandom_range(0, 10)], 1'($urandom)};
         else rd = 8'($urandom);
         if ($urandom_range(0, 39) == 0) do_reset();
         hold(rc, rd, int'($urandom_range(1, 9)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
